// File: rtl/tcam_lookup_arbiter.sv
// Round-robin arbiter sharing one TCAM lookup port among N_REQ requesters.
// An in-order tag FIFO steers each returned rule ID back to the requester that issued it.
module tcam_lookup_arbiter #(
    parameter int N_REQ    = 4,
    parameter int w_key    = 104,
    parameter int w_ruleID = 16,
    parameter int D_TAG    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*w_key-1:0] req_key,
    output logic [N_REQ-1:0]       req_grant,
    output logic                   tcam_key_valid,
    output logic [w_key-1:0]       tcam_key,
    input  logic                   tcam_key_ready,
    input  logic                   tcam_ruleID_valid,
    input  logic [w_ruleID-1:0]    tcam_ruleID,
    input  logic                   tcam_hit,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [w_ruleID-1:0]    resp_ruleID,
    output logic                   resp_hit,
    input  logic                   cfg_hold,
    output logic                   hold_ack,
    output logic [31:0]            lookup_cnt,
    output logic [31:0]            hit_cnt,
    output logic                   err_orphan
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (D_TAG > 1) ? $clog2(D_TAG) : 1;
    localparam int OUT_W = $clog2(D_TAG + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OUT_W-1:0]     outstanding_q, outstanding_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [N_REQ-1:0]     req_grant_q, req_grant_d;
    logic                 tcam_key_valid_q, tcam_key_valid_d;
    logic [w_key-1:0]     tcam_key_q, tcam_key_d;
    logic [N_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic [w_ruleID-1:0]  resp_ruleID_q, resp_ruleID_d;
    logic                 resp_hit_q, resp_hit_d;
    logic [31:0]          lookup_cnt_q, lookup_cnt_d;
    logic [31:0]          hit_cnt_q, hit_cnt_d;
    logic                 err_orphan_q, err_orphan_d;

    logic [IDX_W-1:0]     tag_mem [D_TAG];
    logic [w_key-1:0]     key_arr [N_REQ];
    logic [N_REQ-1:0]     eligible;
    logic [IDX_W:0]       scan_idx;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic                 issue;
    logic                 pop;
    logic                 orphan;
    logic [IDX_W-1:0]     pop_tag;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_key_slice
        assign key_arr[gi] = req_key[gi*w_key +: w_key];
    end

    // A requester granted last cycle sits out one cycle so it cannot be granted back-to-back.
    assign eligible = req_valid & ~req_grant_q;

    // Scan from high offset down so the lowest offset above rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
            end
            if (eligible[scan_idx[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign issue = (state_q == ST_RUN) && !cfg_hold && tcam_key_ready
                   && (outstanding_q < OUT_W'(D_TAG)) && win_found;
    assign pop     = tcam_ruleID_valid && (outstanding_q != '0);
    assign orphan  = tcam_ruleID_valid && (outstanding_q == '0);
    assign pop_tag = tag_mem[rd_ptr_q];

    always_comb begin
        rr_ptr_d         = rr_ptr_q;
        outstanding_d    = outstanding_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        req_grant_d      = '0;
        tcam_key_valid_d = 1'b0;
        tcam_key_d       = tcam_key_q;
        resp_valid_d     = '0;
        resp_ruleID_d    = resp_ruleID_q;
        resp_hit_d       = resp_hit_q;
        lookup_cnt_d     = lookup_cnt_q;
        hit_cnt_d        = hit_cnt_q;
        err_orphan_d     = err_orphan_q || orphan;

        if (issue) begin
            req_grant_d      = N_REQ'(1) << win_idx;
            tcam_key_valid_d = 1'b1;
            tcam_key_d       = key_arr[win_idx];
            rr_ptr_d         = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            wr_ptr_d         = (wr_ptr_q == PTR_W'(D_TAG - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            lookup_cnt_d     = lookup_cnt_q + 32'd1;
        end

        if (pop) begin
            resp_valid_d  = N_REQ'(1) << pop_tag;
            resp_ruleID_d = tcam_ruleID;
            resp_hit_d    = tcam_hit;
            rd_ptr_d      = (rd_ptr_q == PTR_W'(D_TAG - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            if (tcam_hit) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end

        case ({issue, pop})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // DRAIN completes once this cycle's result (if any) retires the last outstanding lookup.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (cfg_hold) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!cfg_hold) begin
                    state_d = ST_RUN;
                end else if (outstanding_d == '0) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!cfg_hold) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Tag storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr_q] <= win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= ST_RUN;
            rr_ptr_q         <= '0;
            outstanding_q    <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            req_grant_q      <= '0;
            tcam_key_valid_q <= 1'b0;
            tcam_key_q       <= '0;
            resp_valid_q     <= '0;
            resp_ruleID_q    <= '0;
            resp_hit_q       <= 1'b0;
            lookup_cnt_q     <= '0;
            hit_cnt_q        <= '0;
            err_orphan_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            outstanding_q    <= outstanding_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            req_grant_q      <= req_grant_d;
            tcam_key_valid_q <= tcam_key_valid_d;
            tcam_key_q       <= tcam_key_d;
            resp_valid_q     <= resp_valid_d;
            resp_ruleID_q    <= resp_ruleID_d;
            resp_hit_q       <= resp_hit_d;
            lookup_cnt_q     <= lookup_cnt_d;
            hit_cnt_q        <= hit_cnt_d;
            err_orphan_q     <= err_orphan_d;
        end
    end

    assign req_grant      = req_grant_q;
    assign tcam_key_valid = tcam_key_valid_q;
    assign tcam_key       = tcam_key_q;
    assign resp_valid     = resp_valid_q;
    assign resp_ruleID    = resp_ruleID_q;
    assign resp_hit       = resp_hit_q;
    assign hold_ack       = (state_q == ST_HELD);
    assign lookup_cnt     = lookup_cnt_q;
    assign hit_cnt        = hit_cnt_q;
    assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_tcam_lookup_arbiter.sv
// Bench for tcam_lookup_arbiter: directed scenarios plus a random phase, every cycle
// compared against a queue-based reference model of the arbiter's rules.
module tb_tcam_lookup_arbiter;
    localparam int N_REQ = 4;
    localparam int W_KEY = 104;
    localparam int W_RID = 16;
    localparam int D_TAG = 4;
    localparam int ST_RUN   = 0;
    localparam int ST_DRAIN = 1;
    localparam int ST_HELD  = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*W_KEY-1:0] req_key;
    logic [N_REQ-1:0]       req_grant;
    logic                   tcam_key_valid;
    logic [W_KEY-1:0]       tcam_key;
    logic                   tcam_key_ready;
    logic                   tcam_ruleID_valid;
    logic [W_RID-1:0]       tcam_ruleID;
    logic                   tcam_hit;
    logic [N_REQ-1:0]       resp_valid;
    logic [W_RID-1:0]       resp_ruleID;
    logic                   resp_hit;
    logic                   cfg_hold;
    logic                   hold_ack;
    logic [31:0]            lookup_cnt;
    logic [31:0]            hit_cnt;
    logic                   err_orphan;

    tcam_lookup_arbiter #(
        .N_REQ(N_REQ), .w_key(W_KEY), .w_ruleID(W_RID), .D_TAG(D_TAG)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_key(req_key), .req_grant(req_grant),
        .tcam_key_valid(tcam_key_valid), .tcam_key(tcam_key), .tcam_key_ready(tcam_key_ready),
        .tcam_ruleID_valid(tcam_ruleID_valid), .tcam_ruleID(tcam_ruleID), .tcam_hit(tcam_hit),
        .resp_valid(resp_valid), .resp_ruleID(resp_ruleID), .resp_hit(resp_hit),
        .cfg_hold(cfg_hold), .hold_ack(hold_ack),
        .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int          m_rr;
    logic [3:0]  m_grant;
    logic        m_kv;
    logic [W_KEY-1:0] m_key;
    int          m_tags[$];
    logic [3:0]  m_resp;
    logic [W_RID-1:0] m_rid;
    logic        m_hitf;
    int          m_state;
    logic [31:0] m_lookups;
    logic [31:0] m_hits;
    logic        m_orphan;

    int auto_lat = 0;
    int pend[$];
    int resp_seen[N_REQ];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < N_REQ; i++) if (v == (4'd1 << i)) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_grant = '0; m_kv = 1'b0; m_key = '0; m_tags.delete();
        m_resp = '0; m_rid = '0; m_hitf = 1'b0; m_state = ST_RUN;
        m_lookups = '0; m_hits = '0; m_orphan = 1'b0;
    endtask

    task automatic check_all();
        chk("req_grant", 128'(req_grant), 128'(m_grant));
        chk("tcam_key_valid", 128'(tcam_key_valid), 128'(m_kv));
        chk("tcam_key", 128'(tcam_key), 128'(m_key));
        chk("resp_valid", 128'(resp_valid), 128'(m_resp));
        chk("resp_ruleID", 128'(resp_ruleID), 128'(m_rid));
        chk("resp_hit", 128'(resp_hit), 128'(m_hitf));
        chk("hold_ack", 128'(hold_ack), 128'(m_state == ST_HELD));
        chk("lookup_cnt", 128'(lookup_cnt), 128'(m_lookups));
        chk("hit_cnt", 128'(hit_cnt), 128'(m_hits));
        chk("err_orphan", 128'(err_orphan), 128'(m_orphan));
    endtask

    task automatic randomize_keys();
        logic [127:0] r;
        for (int i = 0; i < N_REQ; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            req_key[i*W_KEY +: W_KEY] = r[W_KEY-1:0];
        end
    endtask

    // One clock: predict from the rules, advance, compare every output.
    task automatic step();
        logic [3:0] elig;
        logic [W_KEY-1:0] k_w;
        int  w;
        bit  issue, pop, orph;
        int  t;
        randomize_keys();
        if (auto_lat > 0) begin
            if (pend.size() > 0 && pend[0] <= cyc) begin
                void'(pend.pop_front());
                tcam_ruleID_valid = 1'b1;
                tcam_ruleID = 16'($urandom);
                tcam_hit = 1'($urandom);
            end else begin
                tcam_ruleID_valid = 1'b0;
            end
        end
        elig  = req_valid & ~m_grant;
        issue = (m_state == ST_RUN) && !cfg_hold && tcam_key_ready
                && (m_tags.size() < D_TAG) && (elig != 0);
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (m_rr + k) % N_REQ;
            if (w < 0 && elig[c]) w = c;
        end
        if (w < 0) w = 0;
        k_w  = req_key[w*W_KEY +: W_KEY];
        pop  = tcam_ruleID_valid && (m_tags.size() > 0);
        orph = tcam_ruleID_valid && (m_tags.size() == 0);

        @(posedge clk);
        #1;
        cyc++;

        if (pop) begin
            t = m_tags.pop_front();
            m_resp = 4'd1 << t;
            m_rid  = tcam_ruleID;
            m_hitf = tcam_hit;
            if (tcam_hit) m_hits = m_hits + 32'd1;
        end else begin
            m_resp = '0;
        end
        if (orph) m_orphan = 1'b1;
        if (issue) begin
            m_tags.push_back(w);
            m_grant = 4'd1 << w;
            m_kv = 1'b1;
            m_key = k_w;
            m_rr = (w + 1) % N_REQ;
            m_lookups = m_lookups + 32'd1;
        end else begin
            m_grant = '0;
            m_kv = 1'b0;
        end
        case (m_state)
            ST_RUN:   if (cfg_hold) m_state = ST_DRAIN;
            ST_DRAIN: if (!cfg_hold) m_state = ST_RUN;
                      else if (m_tags.size() == 0) m_state = ST_HELD;
            default:  if (!cfg_hold) m_state = ST_RUN;
        endcase

        check_all();
        for (int i = 0; i < N_REQ; i++) if (resp_valid[i]) resp_seen[i]++;
        if (auto_lat > 0 && tcam_key_valid) pend.push_back(cyc + auto_lat);
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = '0; cfg_hold = 1'b0; tcam_key_ready = 1'b1;
        tcam_ruleID_valid = 1'b0; tcam_ruleID = '0; tcam_hit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        pend.delete();
        auto_lat = 0;
        check_all();
    endtask

    task automatic drain();
        req_valid = '0;
        cfg_hold = 1'b0;
        auto_lat = 0;
        pend.delete();
        for (int i = 0; i < 12 && m_tags.size() > 0; i++) begin
            tcam_ruleID_valid = 1'b1;
            tcam_ruleID = 16'($urandom);
            tcam_hit = 1'($urandom);
            step();
        end
        tcam_ruleID_valid = 1'b0;
        step();
    endtask

    task automatic auto_drain();
        req_valid = '0;
        for (int i = 0; i < 30 && (pend.size() > 0 || m_tags.size() > 0); i++) step();
        auto_lat = 0;
        tcam_ruleID_valid = 1'b0;
        step();
    endtask

    initial begin : main
        int grants[$];
        int n_iss;
        logic [31:0] h0;
        logic [15:0] rid_tab [3];
        logic        hit_tab [3];
        rid_tab[0] = 16'h0003; rid_tab[1] = 16'hffff; rid_tab[2] = 16'h0000;
        hit_tab[0] = 1'b1;     hit_tab[1] = 1'b0;     hit_tab[2] = 1'b1;
        req_key = '0;
        do_reset();

        // All four requesters continuously valid, TCAM latency 2
        for (int i = 0; i < N_REQ; i++) resp_seen[i] = 0;
        req_valid = 4'hF; auto_lat = 2;
        for (int i = 0; i < 40 && grants.size() < 8; i++) begin
            step();
            if (req_grant != 0) grants.push_back(oh2i(req_grant));
            if (grants.size() == 8) req_valid = '0;
        end
        chk("rr_grant_count", 128'(grants.size()), 128'(8));
        for (int i = 0; i < grants.size(); i++) chk("rr_order", 128'(grants[i]), 128'(i % 4));
        auto_drain();
        chk("rr_lookup_cnt", 128'(lookup_cnt), 128'(8));
        for (int i = 0; i < N_REQ; i++) chk("rr_resp_per_req", 128'(resp_seen[i]), 128'(2));

        // Single requester held high: grants alternate
        req_valid = 4'b0100; auto_lat = 2;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("alt_grant", 128'(req_grant), 128'((i % 2 == 0) ? 4 : 0));
        end
        auto_drain();

        // TCAM withholds results: four issues then stall until one returns
        req_valid = 4'hF; tcam_ruleID_valid = 1'b0; n_iss = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tcam_key_valid) n_iss++;
        end
        chk("stall_issues", 128'(n_iss), 128'(4));
        chk("stall_kv", 128'(tcam_key_valid), 128'(0));
        tcam_ruleID_valid = 1'b1; tcam_ruleID = 16'h1234; tcam_hit = 1'b0;
        step();
        chk("stall_pop_cycle_kv", 128'(tcam_key_valid), 128'(0));
        tcam_ruleID_valid = 1'b0;
        step();
        chk("fifth_issue", 128'(tcam_key_valid), 128'(1));
        chk("fifth_lookup_cnt", 128'(lookup_cnt), 128'(17));
        drain();

        // Hold request with three lookups in flight
        req_valid = 4'hF;
        repeat (3) step();
        cfg_hold = 1'b1;
        step();
        chk("hold_same_cycle_kv", 128'(tcam_key_valid), 128'(0));
        repeat (2) begin
            step();
            chk("drain_no_issue", 128'(tcam_key_valid), 128'(0));
            chk("drain_hold_ack", 128'(hold_ack), 128'(0));
        end
        for (int i = 0; i < 3; i++) begin
            tcam_ruleID_valid = 1'b1; tcam_ruleID = 16'(i + 7); tcam_hit = 1'b0;
            step();
            chk("drain_result_ack", 128'(hold_ack), 128'((i == 2) ? 1 : 0));
        end
        tcam_ruleID_valid = 1'b0;
        step();
        chk("held_ack", 128'(hold_ack), 128'(1));
        cfg_hold = 1'b0;
        step();
        chk("release_ack", 128'(hold_ack), 128'(0));
        step();
        chk("release_issue", 128'(tcam_key_valid), 128'(1));
        drain();

        // Orphan result with nothing outstanding
        h0 = m_hits;
        tcam_ruleID_valid = 1'b1; tcam_hit = 1'b1; tcam_ruleID = 16'h00aa;
        step();
        tcam_ruleID_valid = 1'b0;
        chk("orphan_flag", 128'(err_orphan), 128'(1));
        chk("orphan_no_resp", 128'(resp_valid), 128'(0));
        chk("orphan_hit_cnt", 128'(hit_cnt), 128'(h0));
        step();
        chk("orphan_sticky", 128'(err_orphan), 128'(1));

        // Reset with lookups outstanding discards their tags
        req_valid = 4'hF;
        repeat (2) step();
        do_reset();
        chk("reset_clears_orphan", 128'(err_orphan), 128'(0));
        tcam_ruleID_valid = 1'b1; tcam_hit = 1'b1;
        step();
        tcam_ruleID_valid = 1'b0;
        chk("post_reset_orphan", 128'(err_orphan), 128'(1));
        chk("post_reset_no_resp", 128'(resp_valid), 128'(0));

        // Hit pattern 1,0,1 with boundary rule IDs, then hit counter wrap
        do_reset();
        req_valid = 4'hF;
        repeat (3) step();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tcam_ruleID_valid = 1'b1; tcam_ruleID = rid_tab[i]; tcam_hit = hit_tab[i];
            step();
            chk("pat_resp_valid", 128'(resp_valid), 128'(4'd1 << i));
            chk("pat_ruleID", 128'(resp_ruleID), 128'(rid_tab[i]));
            chk("pat_hit", 128'(resp_hit), 128'(hit_tab[i]));
        end
        tcam_ruleID_valid = 1'b0;
        chk("pat_hit_cnt", 128'(hit_cnt), 128'(2));
        @(negedge clk);
        force dut.hit_cnt_q = 32'hffff_fffe;
        #1;
        release dut.hit_cnt_q;
        m_hits = 32'hffff_fffe;
        req_valid = 4'hF;
        repeat (2) step();
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            tcam_ruleID_valid = 1'b1; tcam_ruleID = 16'(i); tcam_hit = 1'b1;
            step();
            chk("wrap_hit_cnt", 128'(hit_cnt), 128'((i == 0) ? 32'hffff_ffff : 32'h0));
        end
        tcam_ruleID_valid = 1'b0;
        step();

        // Random phase
        for (int i = 0; i < 500; i++) begin
            req_valid = 4'($urandom);
            tcam_key_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) cfg_hold = ~cfg_hold;
            tcam_ruleID_valid = ($urandom_range(0, 2) == 0);
            tcam_ruleID = 16'($urandom);
            tcam_hit = 1'($urandom);
            step();
        end
        tcam_key_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tcam_lookup_arbiter.md
TCAM_LOOKUP_ARBITER -- requirements
Module: tcam_lookup_arbiter

Interface
REQ-001 The block SHALL have parameters: N_REQ = 4 (number of requesters), w_key = 104 (key width), w_ruleID = 16 (rule ID width), D_TAG = 4 (maximum outstanding lookups).
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  single clock.
- reset  in  1  reset, synchronous and active-low.
- req_valid  in  N_REQ  requester i has a key pending.
- req_key  in  N_REQ*w_key  key of requester i in bits [i*w_key +: w_key].
- req_grant  out  N_REQ  one-cycle pulse: key of requester i was taken.
- tcam_key_valid  out  1  key issued to the TCAM.
- tcam_key  out  w_key  issued key.
- tcam_key_ready  in  1  TCAM accepts keys.
- tcam_ruleID_valid  in  1  TCAM result strobe, results returned in issue order.
- tcam_ruleID  in  w_ruleID  TCAM rule ID.
- tcam_hit  in  1  TCAM hit flag.
- resp_valid  out  N_REQ  one-hot result strobe to requester i.
- resp_ruleID  out  w_ruleID  result rule ID (shared by all requesters).
- resp_hit  out  1  result hit flag (shared by all requesters).
- cfg_hold  in  1  configuration path requests exclusive TCAM access.
- hold_ack  out  1  lookups are drained and no new lookups are being issued.
- lookup_cnt  out  32  number of issued lookups.
- hit_cnt  out  32  number of returned hits.
- err_orphan  out  1  sticky flag: a result arrived with no outstanding lookup.

Function
REQ-003 Arbitration SHALL be round-robin, scanning upward from pointer rr_ptr (2 bits) with wrap; after a grant to requester w, rr_ptr SHALL become w+1 mod N_REQ.
REQ-004 An issue SHALL occur in a cycle only when all of the following hold:
- state is RUN;
- tcam_key_ready = 1;
- outstanding < D_TAG;
- at least one requester is eligible.
REQ-005 Requester i SHALL be eligible when req_valid[i] = 1 and req_grant[i] = 0 in that cycle, so a requester is never granted on two consecutive cycles.
REQ-006 On an issue to winner w, the registered outputs SHALL take these values on the next edge:
- tcam_key_valid = 1;
- tcam_key = key of w;
- req_grant = one-hot(w).
REQ-007 When no issue occurs, tcam_key_valid and req_grant SHALL be 0; tcam_key SHALL hold its last value.
REQ-008 Issue latency SHALL be one cycle, from the cycle in which req_valid is sampled to the cycle tcam_key_valid is high.
REQ-009 On each issue, the winner index SHALL be pushed into a D_TAG-deep tag FIFO.
REQ-010 Each tcam_ruleID_valid SHALL pop the tag FIFO.
REQ-011 A push and a pop in the same cycle SHALL both take effect, with outstanding (0..D_TAG) unchanged.
REQ-012 On a pop of tag t, on the next edge:
- resp_valid SHALL equal one-hot(t);
- resp_ruleID SHALL equal tcam_ruleID;
- resp_hit SHALL equal tcam_hit.
resp_valid SHALL be 0 in all other cycles.
REQ-013 If tcam_ruleID_valid arrives while outstanding = 0, the block SHALL:
- drive no resp_valid;
- leave the FIFO and outstanding unchanged;
- set err_orphan = 1 until reset.
REQ-014 The tag FIFO SHALL never overflow, because issue is blocked while outstanding = D_TAG.
REQ-015 lookup_cnt SHALL increment on each issue; hit_cnt SHALL increment on each popped result with tcam_hit = 1; both SHALL wrap modulo 2^32.
REQ-016 The state machine SHALL have states RUN, DRAIN and HELD:
- RUN -> DRAIN when cfg_hold = 1;
- DRAIN -> HELD when outstanding = 0 and no result is pending;
- HELD -> RUN when cfg_hold = 0;
- DRAIN -> RUN when cfg_hold = 0.
REQ-017 hold_ack SHALL be 1 exactly while state is HELD.
REQ-018 No issue SHALL occur in DRAIN or HELD; results arriving in DRAIN SHALL still be routed to requesters.
REQ-019 If cfg_hold rises in the same cycle as an eligible request, the request SHALL NOT be issued.

Reset
REQ-020 While reset = 0 at a clock edge, the block SHALL set:
- all outputs to 0;
- rr_ptr = 0;
- outstanding = 0 and the tag FIFO emptied;
- state = RUN;
- lookup_cnt = 0, hit_cnt = 0, err_orphan = 0.
REQ-021 A reset with lookups outstanding SHALL discard their tags; any later results are treated as orphans per REQ-013.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- All 4 req_valid = 1 continuously, tcam_key_ready = 1, TCAM latency 2 -> grants in order 0,1,2,3,0,...; each resp_valid lands on the originating requester; lookup_cnt = 8 after 8 issues.
- Only requester 2 valid, held high -> grants on alternating cycles (2, -, 2, -, ...).
- TCAM withholds results, 5 requests pending -> exactly 4 issues, then stall; first result returns -> 5th issue on the next eligible cycle.
- 3 lookups outstanding, cfg_hold = 1 -> no new issue; hold_ack = 1 one cycle after the 3rd result; cfg_hold = 0 -> state RUN and issuing resumes.
- tcam_ruleID_valid with nothing outstanding -> err_orphan = 1, no resp_valid, hit_cnt unchanged.
- Results with tcam_hit pattern 1,0,1 and tcam_ruleID = 16'h0003, 16'hffff, 16'h0000 -> hit_cnt = 2 and resp fields match in order; hit_cnt preset near 2^32-1 via force -> wraps to 0.
